// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - dual-issue hazard scoreboard for the even/odd pipes
// Tracks in-flight destinations per pipe with a countdown to forwardable and gates issue.
module issue_scoreboard #(
  parameter int DEPTH  = 7,
  parameter int LAT_WD = 3,
  parameter int CNT_WD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid_ep,
  input  logic              dec_valid_op,
  input  logic              ra_use_ep,
  input  logic              rb_use_ep,
  input  logic              rc_use_ep,
  input  logic [6:0]        ra_addr_ep,
  input  logic [6:0]        rb_addr_ep,
  input  logic [6:0]        rc_addr_ep,
  input  logic              rt_wr_ep,
  input  logic [6:0]        rt_addr_ep,
  input  logic [LAT_WD-1:0] lat_ep,
  input  logic              ra_use_op,
  input  logic              rb_use_op,
  input  logic              rc_use_op,
  input  logic [6:0]        ra_addr_op,
  input  logic [6:0]        rb_addr_op,
  input  logic [6:0]        rc_addr_op,
  input  logic              rt_wr_op,
  input  logic [6:0]        rt_addr_op,
  input  logic [LAT_WD-1:0] lat_op,
  output logic              issue_ep,
  output logic              issue_op,
  output logic              stall,
  output logic [CNT_WD-1:0] stall_cnt
);

  localparam logic [LAT_WD-1:0] LAT_ONE = LAT_WD'(1);
  localparam logic [LAT_WD-1:0] LAT_MAX = LAT_WD'(DEPTH);

  logic [DEPTH-1:0]  ev_vld_q, od_vld_q;
  logic [6:0]        ev_addr_q [DEPTH];
  logic [6:0]        od_addr_q [DEPTH];
  logic [LAT_WD-1:0] ev_cnt_q  [DEPTH];
  logic [LAT_WD-1:0] od_cnt_q  [DEPTH];
  logic [CNT_WD-1:0] stall_cnt_q, stall_cnt_d;
  logic [127:0]      busy;
  logic              hazard_ep, hazard_op, pair_raw, pair_waw;
  logic [LAT_WD-1:0] ev_ins_cnt_d, od_ins_cnt_d;

  // Countdown loaded at s1 is lat-1, so a dependant may issue exactly lat cycles later.
  function automatic logic [LAT_WD-1:0] init_cnt(input logic [LAT_WD-1:0] lat);
    logic [LAT_WD-1:0] l;
    l = lat;
    if (l == '0)    l = LAT_ONE;
    if (l > LAT_MAX) l = LAT_MAX;
    return l - LAT_ONE;
  endfunction

  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ev_vld_q[k] && ev_cnt_q[k] != '0) busy[ev_addr_q[k]] = 1'b1;
      if (od_vld_q[k] && od_cnt_q[k] != '0) busy[od_addr_q[k]] = 1'b1;
    end
  end

  assign hazard_ep = (ra_use_ep & busy[ra_addr_ep]) | (rb_use_ep & busy[rb_addr_ep]) |
                     (rc_use_ep & busy[rc_addr_ep]);
  assign hazard_op = (ra_use_op & busy[ra_addr_op]) | (rb_use_op & busy[rb_addr_op]) |
                     (rc_use_op & busy[rc_addr_op]);

  // Intra-pair checks only matter when the even slot is really present alongside the odd one.
  assign pair_raw = dec_valid_ep & rt_wr_ep &
                    ((ra_use_op & (ra_addr_op == rt_addr_ep)) |
                     (rb_use_op & (rb_addr_op == rt_addr_ep)) |
                     (rc_use_op & (rc_addr_op == rt_addr_ep)));
  assign pair_waw = dec_valid_ep & rt_wr_ep & rt_wr_op & (rt_addr_ep == rt_addr_op);

  assign issue_ep = dec_valid_ep & ~hazard_ep & ~flush & ~rst;
  assign issue_op = dec_valid_op & ~hazard_op & ~flush & ~rst &
                    (issue_ep | ~dec_valid_ep) & ~pair_raw & ~pair_waw;
  assign stall    = ~flush & ~rst &
                    ((dec_valid_ep & ~issue_ep) | (dec_valid_op & ~issue_op));

  assign ev_ins_cnt_d = (issue_ep & rt_wr_ep) ? init_cnt(lat_ep) : '0;
  assign od_ins_cnt_d = (issue_op & rt_wr_op) ? init_cnt(lat_op) : '0;
  assign stall_cnt_d  = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_WD'(1) : stall_cnt_q;
  assign stall_cnt    = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_vld_q    <= '0;
      od_vld_q    <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ev_addr_q[k] <= '0;
        od_addr_q[k] <= '0;
        ev_cnt_q[k]  <= '0;
        od_cnt_q[k]  <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush) begin
        ev_vld_q <= '0;
        od_vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          ev_cnt_q[k] <= '0;
          od_cnt_q[k] <= '0;
        end
      end else begin
        ev_vld_q     <= {ev_vld_q[DEPTH-2:0], issue_ep & rt_wr_ep};
        od_vld_q     <= {od_vld_q[DEPTH-2:0], issue_op & rt_wr_op};
        ev_addr_q[0] <= rt_addr_ep;
        od_addr_q[0] <= rt_addr_op;
        ev_cnt_q[0]  <= ev_ins_cnt_d;
        od_cnt_q[0]  <= od_ins_cnt_d;
        for (int k = 1; k < DEPTH; k++) begin
          ev_addr_q[k] <= ev_addr_q[k-1];
          od_addr_q[k] <= od_addr_q[k-1];
          ev_cnt_q[k]  <= (ev_cnt_q[k-1] == '0) ? '0 : ev_cnt_q[k-1] - LAT_ONE;
          od_cnt_q[k]  <= (od_cnt_q[k-1] == '0) ? '0 : od_cnt_q[k-1] - LAT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clk, rst, flush;
  logic        dec_valid_ep, dec_valid_op;
  logic        ra_use_ep, rb_use_ep, rc_use_ep, rt_wr_ep;
  logic [6:0]  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [2:0]  lat_ep;
  logic        ra_use_op, rb_use_op, rc_use_op, rt_wr_op;
  logic [6:0]  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [2:0]  lat_op;
  logic        issue_ep, issue_op, stall;
  logic [15:0] stall_cnt;
  int          n_assert;
  int          n_fail;

  issue_scoreboard #(.DEPTH(7), .LAT_WD(3), .CNT_WD(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid_ep(dec_valid_ep), .dec_valid_op(dec_valid_op),
    .ra_use_ep(ra_use_ep), .rb_use_ep(rb_use_ep), .rc_use_ep(rc_use_ep),
    .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep),
    .rt_wr_ep(rt_wr_ep), .rt_addr_ep(rt_addr_ep), .lat_ep(lat_ep),
    .ra_use_op(ra_use_op), .rb_use_op(rb_use_op), .rc_use_op(rc_use_op),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op),
    .rt_wr_op(rt_wr_op), .rt_addr_op(rt_addr_op), .lat_op(lat_op),
    .issue_ep(issue_ep), .issue_op(issue_op), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr_even;
    dec_valid_ep = 0; ra_use_ep = 0; rb_use_ep = 0; rc_use_ep = 0; rt_wr_ep = 0;
    ra_addr_ep = 0; rb_addr_ep = 0; rc_addr_ep = 0; rt_addr_ep = 0; lat_ep = 0;
  endtask

  task automatic clr_odd;
    dec_valid_op = 0; ra_use_op = 0; rb_use_op = 0; rc_use_op = 0; rt_wr_op = 0;
    ra_addr_op = 0; rb_addr_op = 0; rc_addr_op = 0; rt_addr_op = 0; lat_op = 0;
  endtask

  // Advance to 1 time unit after the next rising edge; drives then happen there, checks at +4.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; flush = 0;
    clr_even();
    clr_odd();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; flush = 0;
    clr_even();
    clr_odd();
    dec_valid_ep = 1; dec_valid_op = 1;
    #3;
    n_assert++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b0) begin
      n_fail++; $display("FAIL reset_issue: got ep=%b op=%b want 0 0", issue_ep, issue_op);
    end
    n_assert++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_assert++;
    if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", stall_cnt); end
    clr_even();
    clr_odd();
    cyc();
    rst = 0;
  endtask

  task automatic test_even_chain;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 5; lat_ep = 6;
    #3;
    n_assert++;
    if (issue_ep !== 1'b1) begin n_fail++; $display("FAIL chain_prod_issue: got %b want 1", issue_ep); end
    cyc();
    rt_wr_ep = 0; rt_addr_ep = 0; lat_ep = 1; ra_use_ep = 1; ra_addr_ep = 5;
    for (int k = 1; k <= 5; k++) begin
      #3;
      n_assert++;
      if (issue_ep !== 1'b0 || stall !== 1'b1) begin
        n_fail++; $display("FAIL chain_stall_T+%0d: got issue=%b stall=%b want 0 1", k, issue_ep, stall);
      end
      cyc();
    end
    #3;
    n_assert++;
    if (issue_ep !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL chain_issue_T+6: got issue=%b stall=%b want 1 0", issue_ep, stall);
    end
    n_assert++;
    if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL chain_cnt: got %0d want 5", stall_cnt); end
    cyc();
    clr_even();
  endtask

  task automatic test_pair_raw;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 10; lat_ep = 2;
    dec_valid_op = 1; rb_use_op = 1; rb_addr_op = 10;
    #3;
    n_assert++;
    if (issue_ep !== 1'b1 || issue_op !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL raw_split: got ep=%b op=%b stall=%b want 1 0 1", issue_ep, issue_op, stall);
    end
    cyc();
    clr_even();
    #3;
    n_assert++;
    if (issue_op !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL raw_T+1: got op=%b stall=%b want 0 1", issue_op, stall);
    end
    cyc();
    #3;
    n_assert++;
    if (issue_op !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL raw_T+2: got op=%b stall=%b want 1 0", issue_op, stall);
    end
    n_assert++;
    if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_cnt: got %0d want 2", stall_cnt); end
    cyc();
    clr_odd();
  endtask

  task automatic test_pair_waw;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 3; lat_ep = 3;
    dec_valid_op = 1; rt_wr_op = 1; rt_addr_op = 3; lat_op = 2;
    #3;
    n_assert++;
    if (issue_ep !== 1'b1 || issue_op !== 1'b0) begin
      n_fail++; $display("FAIL waw_split: got ep=%b op=%b want 1 0", issue_ep, issue_op);
    end
    cyc();
    clr_even();
    #3;
    n_assert++;
    if (issue_op !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_T+1: got op=%b stall=%b want 1 0", issue_op, stall);
    end
    cyc();
    clr_odd();
  endtask

  task automatic test_flush;
    do_reset();
    dec_valid_op = 1; rt_wr_op = 1; rt_addr_op = 7; lat_op = 4;
    #3;
    n_assert++;
    if (issue_op !== 1'b1) begin n_fail++; $display("FAIL flush_prod: got %b want 1", issue_op); end
    cyc();
    clr_odd();
    flush = 1;
    dec_valid_ep = 1; ra_use_ep = 1; ra_addr_ep = 7;
    #3;
    n_assert++;
    if (issue_ep !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got issue=%b stall=%b want 0 0", issue_ep, stall);
    end
    cyc();
    flush = 0;
    #3;
    n_assert++;
    if (issue_ep !== 1'b1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_after: got issue=%b cnt=%0d want 1 0", issue_ep, stall_cnt);
    end
    cyc();
    clr_even();
  endtask

  task automatic test_even_hazard_blocks_odd;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 20; lat_ep = 5;
    cyc();
    rt_wr_ep = 0; rt_addr_ep = 0; rc_use_ep = 1; rc_addr_ep = 20;
    dec_valid_op = 1; ra_use_op = 1; ra_addr_op = 21; rt_wr_op = 1; rt_addr_op = 22; lat_op = 1;
    #3;
    n_assert++;
    if (issue_ep !== 1'b0 || issue_op !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL inorder: got ep=%b op=%b stall=%b want 0 0 1", issue_ep, issue_op, stall);
    end
    cyc();
    clr_even();
    #3;
    n_assert++;
    if (issue_op !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL odd_alone: got op=%b stall=%b want 1 0", issue_op, stall);
    end
    cyc();
    clr_odd();
  endtask

  task automatic test_lat_edges;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 12; lat_ep = 0;
    cyc();
    rb_use_ep = 1; rb_addr_ep = 12; rt_addr_ep = 13; lat_ep = 7;
    #3;
    n_assert++;
    if (issue_ep !== 1'b1) begin n_fail++; $display("FAIL lat0_reader: got %b want 1", issue_ep); end
    cyc();
    clr_even();
    dec_valid_op = 1; rc_use_op = 1; rc_addr_op = 13;
    for (int k = 2; k <= 7; k++) begin
      #3;
      n_assert++;
      if (issue_op !== 1'b0) begin n_fail++; $display("FAIL lat7_stall_T+%0d: got %b want 0", k, issue_op); end
      cyc();
    end
    #3;
    n_assert++;
    if (issue_op !== 1'b1 || stall_cnt !== 16'd6) begin
      n_fail++; $display("FAIL lat7_issue: got op=%b cnt=%0d want 1 6", issue_op, stall_cnt);
    end
    cyc();
    clr_odd();
  endtask

  task automatic test_reset_and_saturate;
    do_reset();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 5; lat_ep = 7;
    cyc();
    rt_wr_ep = 0; rt_addr_ep = 0; ra_use_ep = 1; ra_addr_ep = 5;
    cyc();
    #3;
    n_assert++;
    if (stall !== 1'b1 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL midstall: got stall=%b cnt=%0d want 1 1", stall, stall_cnt);
    end
    rst = 1;
    #1;
    n_assert++;
    if (issue_ep !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_rst: got issue=%b stall=%b cnt=%0d want 0 0 0", issue_ep, stall, stall_cnt);
    end
    #2;
    rst = 0;
    cyc();
    #3;
    n_assert++;
    if (issue_ep !== 1'b1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_rst: got issue=%b cnt=%0d want 1 0", issue_ep, stall_cnt);
    end
    cyc();
    // Even keeps writing r1 while odd reads r1: odd is blocked every cycle.
    clr_even();
    dec_valid_ep = 1; rt_wr_ep = 1; rt_addr_ep = 1; lat_ep = 7;
    dec_valid_op = 1; ra_use_op = 1; ra_addr_op = 1;
    for (int i = 0; i < 10; i++) cyc();
    #3;
    n_assert++;
    if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL cnt_10: got %0d want 10", stall_cnt); end
    for (int i = 10; i < 65535; i++) cyc();
    #3;
    n_assert++;
    if (stall_cnt !== 16'hFFFF || stall !== 1'b1) begin
      n_fail++; $display("FAIL cnt_full: got cnt=%h stall=%b want ffff 1", stall_cnt, stall);
    end
    cyc();
    #3;
    n_assert++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat: got %h want ffff", stall_cnt); end
    cyc();
    clr_even();
    clr_odd();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1; flush = 0;
    clr_even();
    clr_odd();
    cyc();
    test_reset();
    test_even_chain();
    test_pair_raw();
    test_pair_waw();
    test_flush();
    test_even_hazard_blocks_odd();
    test_lat_edges();
    test_reset_and_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
